// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//   Multi-cycle multiply/divide unit for the EX stage. Owns the HI/LO
//   registers read by MFHI/MFLO and written by MTHI/MTLO. A multiply or
//   divide is computed into a 64-bit staging register when it starts. The
//   unit then stays busy for a fixed number of cycles before the staged
//   result is committed to HI/LO. The hazard unit uses busy to stall
//   dependent instructions.
//
// Ports
//   clk    in   1   clock, rising edge
//   reset  in   1   asynchronous, active-low reset
//   start  in   1   one-cycle request pulse, qualified by op
//   op     in   3   0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6,7=no-op
//   A      in   32  rs operand (dividend / multiplicand / MT data)
//   B      in   32  rt operand (divisor / multiplier)
//   busy   out  1   operation in progress (decoded from the state register)
//   HI     out  32  HI register
//   LO     out  32  LO register
// ---------------------------------------------------------------------------
module mult_div_unit #(
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic [63:0]       stage_q, stage_d;   // {sh, sl}
   logic              divz_q,  divz_d;    // staged op was a divide by zero
   logic [31:0]       hi_q,    hi_d;
   logic [31:0]       lo_q,    lo_d;

   logic signed [63:0] prod_s;
   logic        [63:0] prod_u;

   // Signed divide on magnitudes so that 0x80000000 / -1 wraps cleanly to
   // 0x80000000 instead of relying on simulator overflow behaviour.
   // Returns {remainder, quotient}; remainder carries the dividend's sign.
   function automatic logic [63:0] div_signed(input logic [31:0] a,
                                              input logic [31:0] b);
      logic [31:0] ma, mb, q, r;
      ma = a[31] ? (~a + 32'd1) : a;
      mb = b[31] ? (~b + 32'd1) : b;
      if (mb == 32'd0) mb = 32'd1;        // result discarded at commit
      q = ma / mb;
      r = ma % mb;
      if (a[31] ^ b[31]) q = ~q + 32'd1;
      if (a[31])         r = ~r + 32'd1;
      return {r, q};
   endfunction

   function automatic logic [63:0] div_unsigned(input logic [31:0] a,
                                                input logic [31:0] b);
      logic [31:0] d;
      d = (b == 32'd0) ? 32'd1 : b;       // result discarded at commit
      return {a % d, a / d};
   endfunction

   assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
   assign prod_u = {32'd0, A} * {32'd0, B};

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic: only the four arithmetic ops (op[2]==0) enter RUN
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start && !op[2]) state_d = ST_RUN;
         ST_RUN:  if (cnt_q == '0)     state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy = (state_q == ST_RUN);
   end

   // Datapath next-state. A start while RUN is deliberately ignored.
   always_comb begin
      cnt_d   = cnt_q;
      stage_d = stage_q;
      divz_d  = divz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      if (state_q == ST_IDLE) begin
         if (start) begin
            case (op)
               OP_MULT: begin
                  stage_d = prod_s;
                  cnt_d   = MUL_LOAD;
                  divz_d  = 1'b0;
               end
               OP_MULTU: begin
                  stage_d = prod_u;
                  cnt_d   = MUL_LOAD;
                  divz_d  = 1'b0;
               end
               OP_DIV: begin
                  stage_d = div_signed(A, B);
                  cnt_d   = DIV_LOAD;
                  divz_d  = (B == 32'd0);
               end
               OP_DIVU: begin
                  stage_d = div_unsigned(A, B);
                  cnt_d   = DIV_LOAD;
                  divz_d  = (B == 32'd0);
               end
               OP_MTHI: hi_d = A;
               OP_MTLO: lo_d = A;
               default: ;
            endcase
         end
      end else begin
         if (cnt_q == '0) begin
            // Divide by zero runs the full sequence but leaves HI/LO alone
            if (!divz_q) begin
               hi_d = stage_q[63:32];
               lo_d = stage_q[31:0];
            end
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q   <= '0;
         stage_q <= '0;
         divz_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         cnt_q   <= cnt_d;
         stage_q <= stage_d;
         divz_q  <= divz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign HI = hi_q;
   assign LO = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
//   Self-checking bench for mult_div_unit. A transaction-level model tracks
//   the remaining busy cycles and the pending result computed with plain
//   64-bit arithmetic; busy/HI/LO are compared every cycle. Directed cases
//   add checks against hand-derived constants.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;

   localparam int MUL_N = 5;
   localparam int DIV_N = 10;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] A, B;
   logic        busy;
   logic [31:0] HI, LO;

   int err_cnt = 0;
   int chk_cnt = 0;

   // Reference model state
   int          m_left;      // busy cycles still to come
   logic [63:0] m_pend;      // {hi, lo} to commit
   bit          m_pend_ok;   // false for divide by zero
   logic [31:0] m_hi, m_lo;

   mult_div_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .HI    (HI),
      .LO    (LO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Architectural result of an arithmetic op: {HI, LO}
   function automatic logic [63:0] ref_result(input logic [2:0] o,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'(int'(a));
      sb = longint'(int'(b));
      case (o)
         3'd0: p = sa * sb;
         3'd1: p = 64'(a) * 64'(b);
         3'd2: begin
            q = sa / sb;
            r = sa % sb;
            p = {r[31:0], q[31:0]};
         end
         default: p = {a % b, a / b};
      endcase
      return p;
   endfunction

   task automatic model_reset();
      m_left    = 0;
      m_pend    = '0;
      m_pend_ok = 1'b0;
      m_hi      = '0;
      m_lo      = '0;
   endtask

   // Advance the model by one rising edge using the current inputs
   task automatic model_step();
      if (m_left > 0) begin
         m_left--;
         if (m_left == 0 && m_pend_ok) begin
            m_hi = m_pend[63:32];
            m_lo = m_pend[31:0];
         end
      end else if (start) begin
         if (op < 3'd4) begin
            m_pend_ok = (op < 3'd2) || (B != 32'd0);
            if (m_pend_ok) m_pend = ref_result(op, A, B);
            m_left = (op < 3'd2) ? MUL_N : DIV_N;
         end else if (op == 3'd4) begin
            m_hi = A;
         end else if (op == 3'd5) begin
            m_lo = A;
         end
      end
   endtask

   // One clock: model update, edge, then compare outputs against the model
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      start = 1'b0;
      op    = 3'($urandom_range(0, 7));
      A     = $urandom;
      B     = $urandom;
      check("busy", 32'(busy), 32'(m_left > 0));
      check("HI", HI, m_hi);
      check("LO", LO, m_lo);
   endtask

   task automatic issue(input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b);
      start = 1'b1;
      op    = o;
      A     = a;
      B     = b;
      tick();
   endtask

   // Arithmetic op with hand-derived result and old HI/LO held during busy
   task automatic run_op(input string tag, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input int n, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo);
      logic [31:0] old_hi, old_lo;
      old_hi = m_hi;
      old_lo = m_lo;
      issue(o, a, b);
      for (int i = 0; i < n; i++) begin
         check({tag, "_busy"}, 32'(busy), 32'd1);
         check({tag, "_hold_hi"}, HI, old_hi);
         check({tag, "_hold_lo"}, LO, old_lo);
         if (i < n - 1) tick();
      end
      tick();
      check({tag, "_done"}, 32'(busy), 32'd0);
      check({tag, "_hi"}, HI, exp_hi);
      check({tag, "_lo"}, LO, exp_lo);
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      op    = 3'd7;
      A     = '0;
      B     = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_hi", HI, 32'd0);
      check("rst_lo", LO, 32'd0);
      reset = 1'b1;
      tick();

      // Preload, then signed and unsigned multiply
      issue(3'd4, 32'h0000_0011, 32'd0);
      issue(3'd5, 32'h0000_0022, 32'd0);
      run_op("mult", 3'd0, 32'hFFFF_FFFD, 32'd5, MUL_N, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, MUL_N, 32'h0000_0001, 32'hFFFF_FFFE);

      // Divides, including the signed overflow corner
      run_op("divu", 3'd3, 32'd100, 32'd7, DIV_N, 32'd2, 32'd14);
      run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, DIV_N, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N, 32'h0, 32'h8000_0000);

      // MTHI / MTLO: single-cycle, other register untouched, never busy
      issue(3'd4, 32'h1234_5678, 32'd0);
      check("mthi_hi", HI, 32'h1234_5678);
      check("mthi_lo", LO, 32'h8000_0000);
      check("mthi_busy", 32'(busy), 32'd0);
      issue(3'd5, 32'h9ABC_DEF0, 32'd0);
      check("mtlo_lo", LO, 32'h9ABC_DEF0);
      check("mtlo_hi", HI, 32'h1234_5678);
      check("mtlo_busy", 32'(busy), 32'd0);

      // No-op codes do nothing
      issue(3'd6, 32'hDEAD_BEEF, 32'd1);
      issue(3'd7, 32'hDEAD_BEEF, 32'd1);
      check("nop_hi", HI, 32'h1234_5678);
      check("nop_lo", LO, 32'h9ABC_DEF0);

      // Divide by zero keeps HI/LO
      issue(3'd4, 32'h0000_00AA, 32'd0);
      issue(3'd5, 32'h0000_00BB, 32'd0);
      run_op("div0", 3'd2, 32'd12345, 32'd0, DIV_N, 32'h0000_00AA, 32'h0000_00BB);

      // Start during RUN is ignored; original result commits on schedule
      issue(3'd0, 32'd7, 32'd6);
      tick();
      start = 1'b1;
      op    = 3'd3;
      A     = 32'd99;
      B     = 32'd3;
      tick();
      start = 1'b1;
      op    = 3'd4;
      A     = 32'h5555_5555;
      tick();
      tick();
      check("ign_busy", 32'(busy), 32'd1);
      tick();
      check("ign_done", 32'(busy), 32'd0);
      check("ign_hi", HI, 32'd0);
      check("ign_lo", LO, 32'd42);
      tick();
      check("ign_idle", 32'(busy), 32'd0);

      // Asynchronous reset mid-run aborts without commit
      issue(3'd0, 32'd9, 32'd9);
      tick();
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_hi", HI, 32'd0);
      check("abort_lo", LO, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      for (int i = 0; i < MUL_N + 3; i++) tick();
      check("abort_nocommit_hi", HI, 32'd0);
      check("abort_nocommit_lo", LO, 32'd0);
      run_op("post_rst", 3'd1, 32'hFFFF_FFFF, 32'd2, MUL_N, 32'h1, 32'hFFFF_FFFE);

      // Randomised traffic against the model, including corner operands
      for (int i = 0; i < 600; i++) begin
         start = ($urandom_range(0, 2) == 0);
         op    = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 5))
            0:       A = 32'h8000_0000;
            1:       A = 32'hFFFF_FFFF;
            default: A = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0:       B = 32'd0;
            1:       B = 32'hFFFF_FFFF;
            2:       B = 32'($urandom_range(1, 15));
            default: B = $urandom;
         endcase
         tick();
      end

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
